// File: rtl/serial_frame_rx_if.sv
// Output word buffer of the serial deframer: a single-entry valid/ready stream.
// The deframer drives data/valid through master; the consumer drives ready through slave.
interface serial_frame_rx_if #(
    parameter int BW_DATA = 8
);
    logic [BW_DATA-1:0] o_Data;
    logic               o_Valid;
    logic               i_Ready;

    modport master (output o_Data, output o_Valid, input  i_Ready);
    modport slave  (input  o_Data, input  o_Valid, output i_Ready);
endinterface

// File: rtl/serial_frame_rx.sv
// One-bit-per-clock serial deframer: start bit, MSB-first data, optional even parity, stop bit.
// Good words land in a single-entry valid/ready buffer; parity/framing/overflow are one-cycle pulses.
module serial_frame_rx #(
    parameter int BW_DATA   = 8,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic                     i_Clk,
    input  logic                     i_Rstn,
    input  logic                     i_Sin,
    serial_frame_rx_if.master        out_if,
    output logic                     o_ParErr,
    output logic                     o_FrmErr,
    output logic                     o_Ovf,
    output logic                     o_Busy
);

    localparam int                 CNT_W    = $clog2(BW_DATA + 1);
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(BW_DATA - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t             state_q,   state_d;
    logic [BW_DATA-1:0] shadow_q,  shadow_d;
    logic [BW_DATA-1:0] data_q,    data_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               par_q,     par_d;
    logic               valid_q,   valid_d;
    logic               par_err_q, par_err_d;
    logic               frm_err_q, frm_err_d;
    logic               ovf_q,     ovf_d;
    logic               busy_q,    busy_d;

    // par_q accumulates the XOR of data bits; after the parity bit it is the error flag.
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        par_d     = par_q;
        valid_d   = valid_q & ~out_if.i_Ready;
        par_err_d = 1'b0;
        frm_err_d = 1'b0;
        ovf_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!i_Sin) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    par_d   = 1'b0;
                end
            end
            DATA: begin
                shadow_d = BW_DATA'({shadow_q, i_Sin});
                par_d    = par_q ^ i_Sin;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = PARITY_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                par_d   = par_q ^ i_Sin;
                state_d = STOP;
            end
            STOP: begin
                state_d = IDLE;
                // Framing error wins over parity error; a full, unconsumed buffer drops the new word.
                if (!i_Sin) begin
                    frm_err_d = 1'b1;
                end else if (PARITY_EN && par_q) begin
                    par_err_d = 1'b1;
                end else if (!valid_q || out_if.i_Ready) begin
                    data_d  = shadow_q;
                    valid_d = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_Clk or negedge i_Rstn) begin
        if (!i_Rstn) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            par_q     <= 1'b0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            par_q     <= par_d;
            valid_q   <= valid_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
        end
    end

    assign out_if.o_Data  = data_q;
    assign out_if.o_Valid = valid_q;
    assign o_ParErr       = par_err_q;
    assign o_FrmErr       = frm_err_q;
    assign o_Ovf          = ovf_q;
    assign o_Busy         = busy_q;

endmodule
